// File: rtl/cfg_chain_pkg.sv
// Shared types for the PLL configuration scan-chain master.
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE_RD,
        ST_SHIFT,
        ST_STROBE_LD,
        ST_FINISH
    } state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/cfg_chain_master_if.sv
// Control-side request/response bundle of the scan-chain master.
interface cfg_chain_master_if #(
    parameter int N = 96
) ();

    logic         start;
    logic         op;
    logic [N-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [N-1:0] rd_data;
    logic         mismatch;

    // Control logic issuing requests
    modport master (
        output start, op, wr_data,
        input  busy, done, rd_data, mismatch
    );

    // Scan-chain master serving requests
    modport slave (
        input  start, op, wr_data,
        output busy, done, rd_data, mismatch
    );

endinterface

// File: rtl/cfg_chain_master_scan_clk_gen.sv
// Scan clock divider: each pulse is HALF cycles low then HALF cycles high.
// sample marks the last low-phase cycle, pulse_end the last high-phase cycle.
module scan_clk_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic sample,
    output logic pulse_end
);

    localparam int DW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

    logic [DW-1:0] div_cnt;
    logic          phase;
    logic          div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Divider and phase register; parked at start of a low phase when disabled
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sclk      = phase;
    assign sample    = en & ~phase & div_wrap;
    assign pulse_end = en &  phase & div_wrap;

endmodule

// File: rtl/cfg_chain_master.sv
// PLL configuration scan-chain master: write+load or read-back+verify of an
// N-bit configuration word over the sclk/sdo/sdi/load/read pins.
module cfg_chain_master
    import cfg_chain_pkg::*;
#(
    parameter int N    = 96,
    parameter int HALF = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cfg_chain_master_if.slave     ctrl,
    output logic                  sclk,
    output logic                  sdo,
    input  logic                  sdi,
    output logic                  load,
    output logic                  read
);

    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic          op_q;
    logic [N-1:0]  shadow;
    logic [N-1:0]  capture;
    logic [N-1:0]  rd_q;
    logic          mismatch_q;
    logic [BW-1:0] bit_cnt;
    logic          run;
    logic          sample;
    logic          pulse_end;
    logic          enter_finish;

    scan_clk_gen #(
        .HALF (HALF)
    ) u_scan_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (run),
        .sclk      (sclk),
        .sample    (sample),
        .pulse_end (pulse_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pin/handshake decode; transitions only at pulse ends so
    // sdo/load/read change at the start of a low phase
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        load      = 1'b0;
        read      = 1'b0;
        sdo       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl.start) begin
                    state_nxt = (ctrl.op == OP_READ) ? ST_STROBE_RD : ST_SHIFT;
                end
            end
            ST_STROBE_RD: begin
                run  = 1'b1;
                read = 1'b1;
                if (pulse_end) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                run = 1'b1;
                sdo = (op_q == OP_WRITE) ? shadow[N-1] : 1'b0;
                if (pulse_end && bit_cnt == BIT_LAST) begin
                    state_nxt = (op_q == OP_READ) ? ST_FINISH : ST_STROBE_LD;
                end
            end
            ST_STROBE_LD: begin
                run  = 1'b1;
                load = 1'b1;
                if (pulse_end) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign enter_finish  = (state != ST_FINISH) && (state_nxt == ST_FINISH);
    assign ctrl.busy     = (state != ST_IDLE) && (state != ST_FINISH);
    assign ctrl.done     = (state == ST_FINISH);
    assign ctrl.rd_data  = rd_q;
    assign ctrl.mismatch = mismatch_q;

    // Shadow/capture datapath; results are registered on entry to FINISH so
    // they are already valid in the done cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= OP_WRITE;
            shadow     <= '0;
            capture    <= '0;
            rd_q       <= '0;
            mismatch_q <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            if (state == ST_IDLE && ctrl.start) begin
                op_q    <= ctrl.op;
                shadow  <= ctrl.wr_data;
                capture <= '0;
                bit_cnt <= '0;
            end
            if (state == ST_SHIFT) begin
                if (sample && op_q == OP_READ) begin
                    capture <= {capture[N-2:0], sdi};
                end
                if (pulse_end) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (op_q == OP_WRITE) begin
                        shadow <= {shadow[N-2:0], 1'b0};
                    end
                end
            end
            if (enter_finish) begin
                if (op_q == OP_READ) begin
                    rd_q       <= capture;
                    mismatch_q <= (capture != shadow);
                end else begin
                    mismatch_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_chain_master.sv
// Scoreboard bench for cfg_chain_master: N=96/HALF=2 and N=8/HALF=1 instances,
// each driving a behavioural model of the chip-side scan chain.
module tb_cfg_chain_master;

    localparam int NA = 96;
    localparam int HA = 2;
    localparam int NB = 8;
    localparam int HB = 1;

    typedef struct {
        logic        op;
        logic [95:0] rd;
        logic        mm;
        logic [95:0] cfg;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cfg_chain_master_if #(.N(NA)) ia ();
    cfg_chain_master_if #(.N(NB)) ib ();

    logic sclk_a, sdo_a, sdi_a, load_a, read_a;
    logic sclk_b, sdo_b, sdi_b, load_b, read_b;

    cfg_chain_master #(.N(NA), .HALF(HA)) dut_a (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ia.slave),
        .sclk  (sclk_a),
        .sdo   (sdo_a),
        .sdi   (sdi_a),
        .load  (load_a),
        .read  (read_a)
    );

    cfg_chain_master #(.N(NB), .HALF(HB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ib.slave),
        .sclk  (sclk_b),
        .sdo   (sdo_b),
        .sdi   (sdi_b),
        .load  (load_b),
        .read  (read_b)
    );

    // Chip-side scan chains
    logic [NA-1:0] sr_a = '0, cfg_a = '0;
    logic [NB-1:0] sr_b = '0, cfg_b = '0;
    always @(posedge sclk_a) begin
        if (load_a)      cfg_a <= sr_a;
        else if (read_a) sr_a  <= cfg_a;
        else             sr_a  <= {sr_a[NA-2:0], sdo_a};
    end
    always @(posedge sclk_b) begin
        if (load_b)      cfg_b <= sr_b;
        else if (read_b) sr_b  <= cfg_b;
        else             sr_b  <= {sr_b[NB-2:0], sdo_b};
    end
    assign sdi_a = sr_a[NA-1];
    assign sdi_b = sr_b[NB-1];

    int passed = 0;
    int total  = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [NA-1:0] model_cfg_a = '0, model_rd_a = '0;
    logic [NB-1:0] model_cfg_b = '0, model_rd_b = '0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Monitor A: operation-level timing and results against queued expectations
    int cyc_a = 0, rises_a = 0, loads_a = 0, reads_a = 0, busy_a = 0, idle_sclk_a = 0;
    int st_a = 0, br_a = 0, bl_a = 0, bd_a = 0, bb_a = 0;
    logic prev_a = 1'b0, first_read_a = 1'b0, first_sdo_a = 1'b0, last_load_a = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc_a++;
        if (!ia.busy && sclk_a) idle_sclk_a++;
        if (sclk_a && !prev_a) begin
            rises_a++;
            if (load_a) loads_a++;
            if (read_a) reads_a++;
            if (rises_a - br_a == 1) begin
                first_read_a = read_a;
                first_sdo_a  = sdo_a;
            end
            if (rises_a - br_a == NA + 1) last_load_a = load_a;
        end
        prev_a = sclk_a;
        if (ia.busy) busy_a++;
        if (reset && ia.start && !ia.busy && !ia.done) begin
            st_a = cyc_a; br_a = rises_a; bl_a = loads_a; bd_a = reads_a; bb_a = busy_a;
        end
        if (ia.done) begin
            if (qa.size() == 0) begin
                chk("a_spurious_done", 96'd1, 96'd0);
            end else begin
                e = qa.pop_front();
                chk("a_rd_data", ia.rd_data, e.rd);
                chk("a_mismatch", 96'(ia.mismatch), 96'(e.mm));
                chk("a_chip_cfg", cfg_a, e.cfg);
                chk("a_latency", 96'(cyc_a - st_a), 96'(2 * HA * (NA + 1) + 1));
                chk("a_busy_cycles", 96'(busy_a - bb_a), 96'(2 * HA * (NA + 1)));
                chk("a_sclk_rises", 96'(rises_a - br_a), 96'(NA + 1));
                chk("a_load_pulses", 96'(loads_a - bl_a), 96'(e.op ? 0 : 1));
                chk("a_read_pulses", 96'(reads_a - bd_a), 96'(e.op ? 1 : 0));
                chk("a_first_pulse_read", 96'(first_read_a), 96'(e.op));
                chk("a_last_pulse_load", 96'(last_load_a), 96'(!e.op));
                chk("a_first_sdo", 96'(first_sdo_a), 96'(e.op ? 1'b0 : e.cfg[NA-1]));
            end
        end
    end

    // Monitor B
    int cyc_b = 0, rises_b = 0, loads_b = 0, reads_b = 0, idle_sclk_b = 0;
    int st_b = 0, br_b = 0, bl_b = 0, bd_b = 0;
    logic prev_b = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc_b++;
        if (!ib.busy && sclk_b) idle_sclk_b++;
        if (sclk_b && !prev_b) begin
            rises_b++;
            if (load_b) loads_b++;
            if (read_b) reads_b++;
        end
        prev_b = sclk_b;
        if (reset && ib.start && !ib.busy && !ib.done) begin
            st_b = cyc_b; br_b = rises_b; bl_b = loads_b; bd_b = reads_b;
        end
        if (ib.done) begin
            if (qb.size() == 0) begin
                chk("b_spurious_done", 96'd1, 96'd0);
            end else begin
                e = qb.pop_front();
                chk("b_rd_data", 96'(ib.rd_data), e.rd);
                chk("b_mismatch", 96'(ib.mismatch), 96'(e.mm));
                chk("b_chip_cfg", 96'(cfg_b), e.cfg);
                chk("b_latency", 96'(cyc_b - st_b), 96'(2 * HB * (NB + 1) + 1));
                chk("b_sclk_rises", 96'(rises_b - br_b), 96'(NB + 1));
                chk("b_load_pulses", 96'(loads_b - bl_b), 96'(e.op ? 0 : 1));
                chk("b_read_pulses", 96'(reads_b - bd_b), 96'(e.op ? 1 : 0));
            end
        end
    end

    task automatic issue_a(input logic opv, input logic [NA-1:0] w, input bit second_start);
        exp_t e;
        e.op = opv;
        if (opv == 1'b0) begin
            model_cfg_a = w;
            e.mm = 1'b0;
        end else begin
            model_rd_a = model_cfg_a;
            e.mm = (model_cfg_a != w);
        end
        e.rd  = model_rd_a;
        e.cfg = model_cfg_a;
        qa.push_back(e);
        @(posedge clk); #1;
        ia.start = 1'b1; ia.op = opv; ia.wr_data = w;
        @(posedge clk); #1;
        ia.start = 1'b0; ia.op = ~opv; ia.wr_data = {$urandom, $urandom, $urandom};
        if (second_start) begin
            repeat (8) @(posedge clk);
            #1;
            ia.start = 1'b1; ia.op = ~opv; ia.wr_data = ~w;
            @(posedge clk); #1;
            ia.start = 1'b0;
        end
        for (int i = 0; i < 2000 && qa.size() != 0; i++) @(negedge clk);
        chk("a_done_within_bound", 96'(qa.size()), 96'd0);
        qa.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic issue_b(input logic opv, input logic [NB-1:0] w);
        exp_t e;
        e.op = opv;
        if (opv == 1'b0) begin
            model_cfg_b = w;
            e.mm = 1'b0;
        end else begin
            model_rd_b = model_cfg_b;
            e.mm = (model_cfg_b != w);
        end
        e.rd  = 96'(model_rd_b);
        e.cfg = 96'(model_cfg_b);
        qb.push_back(e);
        @(posedge clk); #1;
        ib.start = 1'b1; ib.op = opv; ib.wr_data = w;
        @(posedge clk); #1;
        ib.start = 1'b0; ib.op = ~opv; ib.wr_data = 8'($urandom);
        for (int i = 0; i < 200 && qb.size() != 0; i++) @(negedge clk);
        chk("b_done_within_bound", 96'(qb.size()), 96'd0);
        qb.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_state();
        chk("a_reset_ctrl", 96'({ia.busy, ia.done, ia.mismatch}), 96'd0);
        chk("a_reset_pins", 96'({sclk_a, sdo_a, load_a, read_a}), 96'd0);
        chk("a_reset_rd_data", ia.rd_data, 96'd0);
        chk("b_reset_ctrl", 96'({ib.busy, ib.done, ib.mismatch}), 96'd0);
        chk("b_reset_pins", 96'({sclk_b, sdo_b, load_b, read_b}), 96'd0);
        chk("b_reset_rd_data", 96'(ib.rd_data), 96'd0);
    endtask

    initial begin
        logic [NA-1:0] w;
        logic [NA-1:0] one96;
        logic [NB-1:0] one8;
        one96 = 1;
        one8  = 1;
        ia.start = 1'b0; ia.op = 1'b0; ia.wr_data = '0;
        ib.start = 1'b0; ib.op = 1'b0; ib.wr_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        issue_a(1'b0, {12{8'hA5}}, 1'b0);
        issue_a(1'b1, {12{8'hA5}}, 1'b0);
        w = 96'h0123_4567_89AB_CDEF_0000_FFFF;
        issue_a(1'b0, w, 1'b0);
        issue_a(1'b1, w, 1'b0);
        issue_a(1'b1, w ^ (one96 << 40), 1'b0);
        chk("a_rd_bit40_differs", 96'(ia.rd_data[40] ^ w[40]), 96'd0);
        issue_a(1'b0, ~w, 1'b1);
        issue_a(1'b1, ~w, 1'b1);

        // Abort a write mid-shift; the chip must not see a load
        @(posedge clk); #1;
        ia.start = 1'b1; ia.op = 1'b0; ia.wr_data = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        model_rd_a = '0;
        model_rd_b = '0;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("a_abort_no_load", cfg_a, model_cfg_a);
        issue_a(1'b1, model_cfg_a, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic opv;
            opv = 1'($urandom_range(0, 1));
            if (opv == 1'b0) w = {$urandom, $urandom, $urandom};
            else if ($urandom_range(0, 1) == 0) w = model_cfg_a;
            else w = model_cfg_a ^ (one96 << $urandom_range(0, NA - 1));
            issue_a(opv, w, 1'b0);
        end

        issue_b(1'b0, 8'hC3);
        issue_b(1'b1, 8'hC3);
        issue_b(1'b1, 8'hC2);
        for (int k = 0; k < 10; k++) begin
            logic opv;
            logic [NB-1:0] wb;
            opv = 1'($urandom_range(0, 1));
            if (opv == 1'b0) wb = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) wb = model_cfg_b;
            else wb = model_cfg_b ^ (one8 << $urandom_range(0, NB - 1));
            issue_b(opv, wb);
        end

        chk("a_sclk_idle_low", 96'(idle_sclk_a), 96'd0);
        chk("b_sclk_idle_low", 96'(idle_sclk_b), 96'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cfg_chain_master.md
Name: cfg_chain_master

Overview:
- System-side driver for the PLL configuration scan chain.
- Serialises an N-bit configuration word into the chip shift register and issues the load strobe that commits it to the configuration register.
- Can also issue a read strobe, shift the captured configuration word back out, and compare it against an expected word.
- Sits between the control logic and the scan pins (s_in, clk_in, load, read, s_out) of the PLL wrapper.

Parameters:
- N, 96, chain length in bits; must match the wrapper configuration width.
- HALF, 2, clk cycles per scan-clock half period (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = write+load, 1 = read-back+verify; sampled with start.
- wr_data  input  N  word to write (op=0) or expected word (op=1); sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at end of operation.
- rd_data  output  N  last word shifted back (op=1 only).
- mismatch  output  1  valid with done for op=1: rd_data != expected.
- sclk  output  1  scan clock to chip clk_in.
- sdo  output  1  serial data to chip s_in.
- sdi  input  1  serial data from chip s_out.
- load  output  1  chip load strobe.
- read  output  1  chip read strobe.

Behaviour:
- Chip protocol (decided), on rising clk_in:
  - load=1: configuration register <= shift register.
  - read=1: shift register <= configuration register.
  - otherwise: shift register <= {sr[N-2:0], s_in}; s_out = sr[N-1].
- Pulse timing:
  - Every scan pulse is 2*HALF clk cycles: HALF cycles sclk=0, then HALF cycles sclk=1.
  - sdo, load and read change only at the start of the low phase and are held through the high phase.
  - sdi is sampled in the last clk cycle of each low phase.
- Reset (reset=0 at a clk edge): state IDLE; busy=0, done=0, mismatch=0, rd_data=0, sclk=0, sdo=0, load=0, read=0, all counters 0. Reset mid-operation aborts immediately with the same values; no partial load is issued.
- FSM states: IDLE, STROBE_RD, SHIFT, STROBE_LD, FINISH.
  - IDLE: start=1 latches op and wr_data into a shadow register; busy=1 next cycle.
    - op=0 -> SHIFT.
    - op=1 -> STROBE_RD.
  - STROBE_RD: one pulse with read=1, sdo=0 -> SHIFT.
  - SHIFT: N pulses.
    - op=0: sdo = shadow MSB-first, bit N-1 first, shadow shifted left per pulse.
    - op=1: sdo=0 and sdi is shifted into capture LSB-side, so the first sample lands in rd_data[N-1] after N pulses.
    - After the Nth pulse: op=0 -> STROBE_LD; op=1 -> FINISH.
  - STROBE_LD: one pulse with load=1, sdo=0 -> FINISH.
  - FINISH: one cycle.
    - done=1, busy=0.
    - op=1: rd_data updated and mismatch = (capture != expected).
    - op=0: mismatch=0 and rd_data holds its previous value.
    - -> IDLE.
- Latency: N+1 pulses, i.e. (N+1)*2*HALF cycles of busy, then the done cycle. With N=96, HALF=2: 388 busy cycles.
- start while busy is ignored, with no queuing. start in the FINISH cycle is ignored.
- Bit counter is $clog2(N+1) wide and terminates at exactly N. Divider counter wraps at HALF-1.
- sclk idles low; no sclk edges outside an operation.

Decomposition:
- Package cfg_chain_pkg: FSM state enum; op encodings OP_WRITE=0, OP_READ=1.
- One sub-module, scan_clk_gen: HALF divider producing sclk, a low-phase-end strobe (sample point) and a pulse-end strobe.
- The FSM, shadow register and capture register stay in cfg_chain_master.

Test Plan:
- Reset: hold reset=0 mid-SHIFT, release -> all outputs 0, sclk stays low, next start accepted normally.
- Write: op=0, wr_data=96'hA5A5…A5, N=96, HALF=2 -> 97 sclk rising edges, sdo bit 95 on the first; load=1 only during pulse 97; done exactly 389 cycles after start; chip model configuration = A5A5…A5.
- Read match: preload chip model config=96'h0123_4567_89AB_CDEF_0000_FFFF, op=1 with the same expected -> read=1 on pulse 1; rd_data equals that word; mismatch=0; config unchanged (no load).
- Read mismatch: flip config bit 40, repeat -> mismatch=1 with done, rd_data[40] differs.
- Busy ignore: second start at cycle 10 of an operation -> no effect, single done pulse, output identical to a single operation.
- HALF=1, N=8: write 8'hC3 -> 9 pulses of 2 cycles each, done 19 cycles after start, model config 8'hC3.
